// File: rtl/fifo_pkt_wctrl_if.sv
// Packet input stream plus filter verdict strobe feeding the packet write controller.
// master = packet/verdict source, slave = fifo_pkt_wctrl.
interface fifo_pkt_wctrl_if #(
  parameter int W_EL = 20
) ();
  logic [W_EL-1:0] in_data;
  logic            in_valid;
  logic            in_sop;
  logic            in_eop;
  logic            in_ready;
  logic            verdict_valid;
  logic            verdict_drop;

  modport master (
    output in_data, in_valid, in_sop, in_eop, verdict_valid, verdict_drop,
    input  in_ready
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, verdict_valid, verdict_drop,
    output in_ready
  );
endinterface

// File: rtl/fifo_pkt_wctrl.sv
// Packet-aware FIFO write controller: writes beats, then commits or rewinds wptr per verdict.
// Optional FIFO_PKT_WCTRL_STATS_EN adds saturating commit/drop counters.
module fifo_pkt_wctrl #(
  parameter int ADDR_WIDTH    = 11,
  parameter int W_EL          = 20,
  parameter int MAX_PKT_BEATS = 2**ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fifo_pkt_wctrl_if.slave       in_if,
  output logic [W_EL-1:0]       fifo_wdata,
  output logic                  fifo_wen,
  input  logic                  fifo_full,
  input  logic [ADDR_WIDTH:0]   fifo_wptr,
  output logic                  fifo_wrst,
  output logic [ADDR_WIDTH:0]   fifo_rst_wptr,
  output logic [ADDR_WIDTH:0]   commit_wptr,
  output logic                  busy
`ifdef FIFO_PKT_WCTRL_STATS_EN
  ,
  output logic [15:0]           stat_commit_cnt,
  output logic [15:0]           stat_drop_cnt
`endif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] MAX_BEATS = PW'(MAX_PKT_BEATS);

  typedef enum logic [2:0] {
    IDLE, WRITE, VERDICT, DRAIN, COMMIT, ROLLBACK
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  start_ptr_q, start_ptr_d;
  logic [PW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]  commit_wptr_q, commit_wptr_d;
  logic           vseen_q, vseen_d;
  logic           vdrop_q, vdrop_d;
  logic           run_q;
  logic           accept;
  logic [PW-1:0]  beat_inc;
  logic           verdict_hit;
  logic           verdict_is_drop;

  // run_q holds in_ready low while reset is asserted and for the first cycle after.
  assign in_if.in_ready = run_q && (((state_q == IDLE) || (state_q == WRITE)) ? !fifo_full
                                                                               : (state_q == DRAIN));
  assign accept          = in_if.in_valid && in_if.in_ready;
  assign beat_inc        = beat_cnt_q + 1'b1;
  assign verdict_hit     = vseen_q || in_if.verdict_valid;
  assign verdict_is_drop = vseen_q ? vdrop_q : in_if.verdict_drop;

  assign fifo_wdata    = in_if.in_data;
  assign fifo_rst_wptr = start_ptr_q;
  assign commit_wptr   = commit_wptr_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    start_ptr_d   = start_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    commit_wptr_d = commit_wptr_q;
    vseen_d       = vseen_q;
    vdrop_d       = vdrop_q;
    fifo_wen      = 1'b0;
    fifo_wrst     = 1'b0;
    case (state_q)
      IDLE: begin
        // A verdict arriving with the sop beat belongs to the packet it starts.
        if (accept && in_if.in_sop) begin
          fifo_wen    = 1'b1;
          start_ptr_d = fifo_wptr;
          beat_cnt_d  = PW'(1);
          vseen_d     = in_if.verdict_valid;
          vdrop_d     = in_if.verdict_drop;
          if (in_if.in_eop)                 state_d = VERDICT;
          else if (MAX_BEATS == PW'(1))     state_d = DRAIN;
          else                              state_d = WRITE;
        end
      end
      WRITE: begin
        if (in_if.verdict_valid && !vseen_q) begin
          vseen_d = 1'b1;
          vdrop_d = in_if.verdict_drop;
        end
        if (accept) begin
          fifo_wen   = 1'b1;
          beat_cnt_d = beat_inc;
          if (in_if.in_eop)               state_d = VERDICT;
          else if (beat_inc == MAX_BEATS) state_d = DRAIN;
        end
      end
      VERDICT: begin
        if (verdict_hit) state_d = verdict_is_drop ? ROLLBACK : COMMIT;
      end
      DRAIN: begin
        if (accept && in_if.in_eop) state_d = ROLLBACK;
      end
      COMMIT: begin
        commit_wptr_d = fifo_wptr;
        state_d       = IDLE;
      end
      ROLLBACK: begin
        fifo_wrst = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      start_ptr_q   <= '0;
      beat_cnt_q    <= '0;
      commit_wptr_q <= '0;
      vseen_q       <= 1'b0;
      vdrop_q       <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_ptr_q   <= start_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      commit_wptr_q <= commit_wptr_d;
      vseen_q       <= vseen_d;
      vdrop_q       <= vdrop_d;
      run_q         <= 1'b1;
    end
  end

`ifdef FIFO_PKT_WCTRL_STATS_EN
  logic [15:0] stat_commit_q, stat_commit_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  always_comb begin
    stat_commit_d = stat_commit_q;
    stat_drop_d   = stat_drop_q;
    if ((state_q == COMMIT) && (stat_commit_q != 16'hFFFF))
      stat_commit_d = stat_commit_q + 16'd1;
    if ((state_q == ROLLBACK) && (stat_drop_q != 16'hFFFF))
      stat_drop_d = stat_drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_commit_q <= '0;
      stat_drop_q   <= '0;
    end else begin
      stat_commit_q <= stat_commit_d;
      stat_drop_q   <= stat_drop_d;
    end
  end

  assign stat_commit_cnt = stat_commit_q;
  assign stat_drop_cnt   = stat_drop_q;
`endif

endmodule
